// File: rtl/multiword_add_ctrl_pkg.sv
// multiword_add_ctrl_pkg: shared state encoding and width helper
package multiword_add_ctrl_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/multiword_add_ctrl_prefix_adder.sv
// prefix_adder: combinational Kogge-Stone adder with carry-in folded in as bit 0
module prefix_adder
  import multiword_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             carry_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int LV = clog2(WIDTH + 1);
  logic [WIDTH:0] g [0:LV];
  logic [WIDTH:0] p [0:LV];
  // log-depth group generate/propagate; low positions just pass through
  always_comb begin
    g[0] = {x & y, carry_in};
    p[0] = {x ^ y, 1'b0};
    for (int l = 1; l <= LV; l++) begin
      g[l] = g[l-1] | (p[l-1] & (g[l-1] << (1 << (l - 1))));
      p[l] = p[l-1] & ((p[l-1] << (1 << (l - 1))) | ~({(WIDTH+1){1'b1}} << (1 << (l - 1))));
    end
    sum = p[0][WIDTH:1] ^ g[LV][WIDTH-1:0];
    carry_out = g[LV][WIDTH];
  end
endmodule

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: streams long add/sub word-by-word through one adder
module multiword_add_ctrl
  import multiword_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_len_err
);
  localparam int CW = clog2(WORDS);
  state_t state, state_n;
  logic carry_q, op_sub, accept, first, sub_eff, cin, co, forced, is_last, len_err, ovf;
  logic [CW-1:0] word_cnt;
  logic [WIDTH-1:0] b_eff, sum;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign first = state == ST_IDLE;
  assign sub_eff = first ? in_sub : op_sub;
  assign b_eff = sub_eff ? ~in_b : in_b;
  assign cin = first ? in_sub : carry_q;
  assign forced = word_cnt == CW'(WORDS - 1);
  assign is_last = in_last || forced;
  assign len_err = forced && !in_last;
  assign ovf = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
  prefix_adder #(.WIDTH(WIDTH)) u_add (
    .carry_in (cin),
    .x        (in_a),
    .y        (b_eff),
    .sum      (sum),
    .carry_out(co)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  // an accepted beat either closes the operation or keeps it open
  always_comb begin
    state_n = state;
    if (accept) state_n = is_last ? ST_IDLE : ST_RUN;
  end
  // carry chain, op latch, word counter and single-entry output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      carry_q <= 1'b0;
      op_sub <= 1'b0;
      word_cnt <= '0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_last <= 1'b0;
      out_carry <= 1'b0;
      out_ovf <= 1'b0;
      out_len_err <= 1'b0;
    end else if (accept) begin
      carry_q <= co;
      if (first && !is_last) op_sub <= in_sub;
      word_cnt <= is_last ? '0 : word_cnt + CW'(1);
      out_valid <= 1'b1;
      out_sum <= sum;
      out_last <= is_last;
      out_carry <= is_last && co;
      out_ovf <= is_last && ovf;
      out_len_err <= len_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb_multiword_add_ctrl: randomized and directed checks against an integer-arithmetic model
module tb_multiword_add_ctrl;
  logic clk = 0, rst = 0, in_valid = 0, in_sub = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_a = 0, in_b = 0, out_sum;
  logic in_ready, out_valid, out_last, out_carry, out_ovf, out_len_err;
  logic [12:0] got;
  int vec = 0, miss = 0;
  logic [63:0] ma = 0, mb = 0;
  int mn = 0;
  bit msub = 0;
  logic [29:0] dt [8] = '{
    {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0000},
    {8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 4'b0000},
    {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0000},
    {8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 4'b1000},
    {8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b0000},
    {8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 4'b1000},
    {8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 4'b1010},
    {8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 4'b1110}
  };

  assign got = {out_valid, out_sum, out_last, out_carry, out_ovf, out_len_err};
  always #5 clk = ~clk;

  multiword_add_ctrl #(.WIDTH(8), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_len_err(out_len_err)
  );

  // whole-operand arithmetic on the words seen so far; the operation closes at in_last or 4 words
  task automatic model_step(input logic [7:0] a, b, input bit sub, last, output logic [12:0] e);
    logic [63:0] r;
    longint sa, sb, sr;
    int nb;
    bit fl, c, v, le;
    if (mn == 0) msub = sub;
    ma |= 64'(a) << (8 * mn);
    mb |= 64'(b) << (8 * mn);
    mn++;
    nb = 8 * mn;
    r = msub ? ma - mb : ma + mb;
    fl = last || mn == 4;
    le = !last && mn == 4;
    c = msub ? (ma >= mb) : r[nb];
    sa = longint'(ma);
    sb = longint'(mb);
    if (ma[nb-1]) sa -= longint'(1) << nb;
    if (mb[nb-1]) sb -= longint'(1) << nb;
    sr = msub ? sa - sb : sa + sb;
    v = sr >= (longint'(1) << (nb - 1)) || sr < -(longint'(1) << (nb - 1));
    e = {1'b1, r[8*(mn-1) +: 8], fl, fl & c, fl & v, le};
    if (fl) begin
      mn = 0;
      ma = 0;
      mb = 0;
    end
  endtask

  task automatic drive(input logic [7:0] a, b, input bit sub, last);
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_last = last;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    #1;
    vec++;
    if ({got, in_ready} !== {13'b0, 1'b1}) begin
      miss++;
      $display("FAIL reset: got %h ready %b, exp 0000 ready 1", got, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_directed;
    logic [7:0] a, b, es;
    logic s, l;
    logic [3:0] ef;
    for (int i = 0; i < 8; i++) begin
      {a, b, s, l, es, ef} = dt[i];
      drive(a, b, s, l);
      vec++;
      if (got !== {1'b1, es, ef}) begin
        miss++;
        $display("FAIL directed[%0d]: got %h exp %h", i, got, {1'b1, es, ef});
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic [12:0] e;
    int len;
    bit s, l;
    for (int op = 0; op < 40; op++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        s = 1'($urandom);
        l = k == len - 1;
        drive(a, b, s, l);
        model_step(a, b, s, l, e);
        vec++;
        if (got !== e) begin
          miss++;
          $display("FAIL random op%0d beat%0d: got %h exp %h", op, k, got, e);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] a [4], b [4];
    logic [12:0] e, held;
    bit s;
    s = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      a[k] = 8'($urandom);
      b[k] = 8'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      drive(a[k], b[k], s, 0);
      model_step(a[k], b[k], s, 0, e);
      vec++;
      if (got !== e) begin
        miss++;
        $display("FAIL bp beat%0d: got %h exp %h", k, got, e);
      end
    end
    held = e;
    in_valid = 1;
    in_a = a[2];
    in_b = b[2];
    in_sub = s;
    in_last = 0;
    out_ready = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      vec++;
      if ({in_ready, got} !== {1'b0, held}) begin
        miss++;
        $display("FAIL bp hold: ready %b got %h, exp ready 0 got %h", in_ready, got, held);
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    model_step(a[2], b[2], s, 0, e);
    vec++;
    if (got !== e) begin
      miss++;
      $display("FAIL bp beat2: got %h exp %h", got, e);
    end
    drive(a[3], b[3], s, 1);
    model_step(a[3], b[3], s, 1, e);
    vec++;
    if (got !== e) begin
      miss++;
      $display("FAIL bp beat3: got %h exp %h", got, e);
    end
  endtask

  task automatic test_len_err;
    logic [7:0] a, b;
    logic [12:0] e;
    bit s;
    for (int k = 0; k < 5; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = k == 4;
      drive(a, b, s, k == 4);
      model_step(a, b, s, k == 4, e);
      vec++;
      if (got !== e || (k == 3 && got[3:0] !== 4'b1??1 && got[3] !== 1'b1)) begin
        miss++;
        $display("FAIL len_err beat%0d: got %h exp %h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] a, b;
    logic [12:0] e;
    for (int k = 0; k < 2; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      drive(a, b, 0, 0);
      model_step(a, b, 0, 0, e);
      vec++;
      if (got !== e) begin
        miss++;
        $display("FAIL rst_mid beat%0d: got %h exp %h", k, got, e);
      end
    end
    rst = 1;
    #1;
    vec++;
    if (out_valid !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid valid: got %b exp 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst = 0;
    mn = 0;
    ma = 0;
    mb = 0;
    drive(8'hFF, 8'h01, 0, 1);
    vec++;
    if (got !== {1'b1, 8'h00, 4'b1100}) begin
      miss++;
      $display("FAIL rst_mid next: got %h exp %h", got, {1'b1, 8'h00, 4'b1100});
    end
  endtask

  task automatic test_drain;
    in_valid = 0;
    @(posedge clk);
    #1;
    vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miss++;
      $display("FAIL drain: valid %b ready %b, exp valid 0 ready 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_len_err;
    test_drain;
    test_reset_mid;
    test_drain;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/multiword_add_ctrl.md
# multiword_add_ctrl

Sequencer that performs multi-precision add/subtract on operands longer than one datapath word by streaming them word-by-word (least-significant word first) through a single WIDTH-bit adder. Carry is chained across cycles in a register. Results are returned on a registered, back-pressurable output stream. It sits between an operand-fetch stage and a result-writeback stage, so arbitrary-length arithmetic reuses one small adder.

## Interface
- WIDTH, 8: bits per word.
- WORDS, 4: maximum words per operation. Sets the word-counter width: clog2(WORDS), minimum 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand word pair present.
- in_ready  out  1  block accepts the word pair this cycle.
- in_a  in  WIDTH  word of operand A.
- in_b  in  WIDTH  word of operand B.
- in_sub  in  1  operation select, 1 = A−B; sampled only on the first beat of an operation.
- in_last  in  1  marks the most-significant word of the operation.
- out_valid  out  1  result word present.
- out_ready  in  1  downstream accepts the result word.
- out_sum  out  WIDTH  result word.
- out_last  out  1  result word is the final word of the operation.
- out_carry  out  1  unsigned carry-out (add) or not-borrow (sub); valid when out_last=1, else 0.
- out_ovf  out  1  signed overflow of the full-length result; valid when out_last=1, else 0.
- out_len_err  out  1  operation was truncated at WORDS words; valid when out_last=1.

## Operation
- States: IDLE (no operation open), RUN (mid-operation).
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready (single output register, no skid).
- Operand B is b_eff = in_sub_eff ? ~in_b : in_b. in_sub_eff is in_sub on the first beat and the latched op_sub afterwards.
- Carry-in is in_sub on the first beat (IDLE) and carry_q in RUN.
- On accept:
  - load sum = in_a + b_eff + cin into out_sum.
  - load carry_q with the adder carry-out.
  - increment word_cnt.
- IDLE→RUN on an accepted first beat with in_last=0 and WORDS>1. op_sub is latched on this transition.
- RUN→IDLE on an accepted beat with in_last=1, or when word_cnt==WORDS−1 (forced last).
- Forced last:
  - out_last=1 and out_len_err=1.
  - The next accepted beat starts a new operation, even if it carries in_last.
- Normal last: out_len_err=0. An IDLE beat with in_last=1 is a one-word operation, and the state stays IDLE.
- out_ovf on the last word = (in_a[MSB] == b_eff[MSB]) && (sum[MSB] != in_a[MSB]).
- out_carry on the last word = the adder carry-out. For subtraction, 1 means no borrow.
- word_cnt clears to 0 whenever an operation closes.

## Timing
- Latency is 1 cycle from an accepted beat to out_valid.
- Throughput is one word per cycle while out_ready=1.
- out_valid clears on out_ready && !accept. If output handshake and accept happen in the same cycle, the register reloads with the new word.
- out_* stay stable while out_valid && !out_ready.
- Reset values:
  - state=IDLE, carry_q=0, op_sub=0, word_cnt=0.
  - out_valid=0, out_sum=0, out_last=0, out_carry=0, out_ovf=0, out_len_err=0.
  - in_ready=1 combinationally after reset.
- Reset mid-operation discards the partial operation. The next beat is treated as a first beat.
- in_sub is ignored on non-first beats. in_* are don't-care when in_valid=0.

## Structure
- Shared package holds:
  - the state enum: ST_IDLE, ST_RUN.
  - the function clog2 used for the word_cnt width.
- Sub-module: one existing combinational prefix_adder, WIDTH matched. Connect carry_in = cin, x = in_a, y = b_eff.
- This block owns only the FSM, carry register, counter and output register.

## Test plan
All cases use WIDTH=8, WORDS=4, and out_ready=1 unless stated.
- Add, 4 words: A words FF,00,FF,00 and B words 01,00,01,00, in_last on word 4 -> out_sum 00,01,00,01, out_last on word 4, out_carry=0, out_ovf=0.
- Subtract, 2 words: A 00,00, B 01,00, in_sub=1 -> out_sum FF,FF, out_carry=0 (borrow), out_ovf=0.
- Signed overflow, 1 word: A 7F, B 01, in_last=1 -> out_sum 80, out_carry=0, out_ovf=1. Then A 80, B 80 -> out_sum 00, out_carry=1, out_ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles mid-operation -> in_ready=0 for those cycles and out_sum held. The sequence completes with correct sums and no lost or duplicated words.
- Length error: 5 beats with no in_last -> beat 4 output has out_last=1 and out_len_err=1. Beat 5 starts a new operation, using in_sub as its carry-in.
- Reset mid-operation: assert rst after word 2 of 4 -> out_valid=0 immediately. The next beat, with A FF and B 01 sent as add with in_last=1, gives out_sum 00 and out_carry=1.
